i2s_rx: RTL

- Receive-side counterpart of the team's I2S transmitter.
- Takes an externally clocked I2S stream (BCK, LRCK, DATA) into the clk domain and deserialises the left and right slots.
- Delivers one signed stereo sample pair per frame with a single-cycle valid strobe.
- Intended use is ADC/codec capture on a MAX1000-class board with clk = 73.728 MHz and BCK = 64·fs (3.072 MHz at fs = 48 kHz).

---
 rtl/i2s_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// I2S receiver: brings an external BCK/LRCK/DATA stream into the clk domain and
// deserialises it into one signed stereo sample pair per frame. Framing errors and
// loss of BCK drop lock and return the receiver to a search for the next frame start.
module i2s_rx #(
    parameter int unsigned SLOT_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bck,
    input  logic                 lrck,
    input  logic                 data,
    output logic [OUT_WIDTH-1:0] out_left,
    output logic [OUT_WIDTH-1:0] out_right,
    output logic                 out_valid,
    output logic                 locked,
    output logic                 frame_err
);

    localparam int unsigned CntW = $clog2(2 * SLOT_WIDTH);
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

    localparam logic [CntW-1:0]      CntMax  = CntW'(2 * SLOT_WIDTH - 1);
    localparam logic [CntW-1:0]      LastBit = CntW'(SLOT_WIDTH - 1);
    localparam logic [ToW-1:0]       ToMax   = ToW'(TIMEOUT);
    localparam logic [ToW-1:0]       ToPre   = ToW'(TIMEOUT - 1);
    localparam logic [OUT_WIDTH-1:0] MsbOne  = OUT_WIDTH'(1) << (OUT_WIDTH - 1);

    typedef enum logic [1:0] {
        StSearch,
        StLeft,
        StRight
    } state_e;

    logic [2:0]           bck_s_q;
    logic [1:0]           lrck_s_q;
    logic [1:0]           data_s_q;

    state_e               state_q;
    logic                 ws_q;
    logic [CntW-1:0]      bit_cnt_q;
    logic [ToW-1:0]       to_q;
    logic [OUT_WIDTH-1:0] sh_q;
    logic [OUT_WIDTH-1:0] left_buf_q;
    logic [OUT_WIDTH-1:0] out_left_q;
    logic [OUT_WIDTH-1:0] out_right_q;
    logic                 out_valid_q;
    logic                 locked_q;
    logic                 frame_err_q;

    logic                 bck_rise;
    logic                 word_end;
    logic                 len_ok;
    logic [OUT_WIDTH-1:0] bit_mask;
    logic [OUT_WIDTH-1:0] cur_word;

    assign bck_rise = bck_s_q[1] & ~bck_s_q[2];
    assign word_end = bck_rise & (lrck_s_q[1] != ws_q);
    assign len_ok   = (bit_cnt_q == LastBit);

    // Current word including the bit being sampled now; bits past OUT_WIDTH shift out of the mask.
    always_comb begin
        bit_mask = MsbOne >> bit_cnt_q;
        cur_word = data_s_q[1] ? (sh_q | bit_mask) : (sh_q & ~bit_mask);
    end

    // Two-flop synchronisers, plus a third BCK flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            bck_s_q  <= '0;
            lrck_s_q <= '0;
            data_s_q <= '0;
        end else begin
            bck_s_q  <= {bck_s_q[1:0], bck};
            lrck_s_q <= {lrck_s_q[0], lrck};
            data_s_q <= {data_s_q[0], data};
        end
    end

    // Framing FSM with bit counter, deserialiser, BCK watchdog and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StSearch;
            ws_q        <= 1'b0;
            bit_cnt_q   <= '0;
            to_q        <= '0;
            sh_q        <= '0;
            left_buf_q  <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (bck_rise) begin
                to_q <= '0;
                ws_q <= lrck_s_q[1];
                if (word_end) begin
                    // The bit sampled here is the LSB of the word owned by ws_q.
                    bit_cnt_q <= '0;
                    sh_q      <= '0;
                    unique case (state_q)
                        StSearch: begin
                            if (ws_q) begin
                                state_q <= StLeft;
                            end
                        end
                        StLeft: begin
                            if (len_ok) begin
                                left_buf_q <= cur_word;
                                state_q    <= StRight;
                            end else begin
                                frame_err_q <= 1'b1;
                                locked_q    <= 1'b0;
                                state_q     <= StSearch;
                            end
                        end
                        StRight: begin
                            if (len_ok) begin
                                out_left_q  <= left_buf_q;
                                out_right_q <= cur_word;
                                out_valid_q <= 1'b1;
                                locked_q    <= 1'b1;
                                state_q     <= StLeft;
                            end else begin
                                frame_err_q <= 1'b1;
                                locked_q    <= 1'b0;
                                state_q     <= StSearch;
                            end
                        end
                        default: state_q <= StSearch;
                    endcase
                end else begin
                    sh_q <= cur_word;
                    if (bit_cnt_q != CntMax) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
            end else if (to_q != ToMax) begin
                to_q <= to_q + 1'b1;
                // Fires only on the step into saturation, so one pulse per BCK loss.
                if (to_q == ToPre) begin
                    frame_err_q <= 1'b1;
                    locked_q    <= 1'b0;
                    state_q     <= StSearch;
                    bit_cnt_q   <= '0;
                    sh_q        <= '0;
                end
            end
        end
    end

    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign out_valid = out_valid_q;
    assign locked    = locked_q;
    assign frame_err = frame_err_q;

endmodule
